pe_net_feeder: RTL and testbench
================================

Name: pe_net_feeder

Overview:
- Source-side driver for the PE array: it is the transmitter for the array's row-parallel data, weight and control inputs.
- Accepts weight taps and pixels from upstream over valid/ready handshakes.
- Buffers one full kernel of weights, then shifts it into the array as one contiguous w_conf burst.
- Issues the single-cycle cntl_conf, then streams one frame of row-parallel pixels with per-row enables.

Parameters:
- ROW_SIZE, 4, number of PE rows driven in parallel
- N, 4, pixel data width per row
- M, 2, weight width per row
- CL_IN, 4, channel-enable/bypass bits per row
- CL1, 2, bypass-source bits per row
- KSZ, 9, weight taps per kernel (length of the w_conf burst)
- LINES, 16, pixels per frame line
- FRAME_LINES, 16, lines per frame

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one load+stream sequence (honoured only in IDLE)
- cfg_d_ch  in  ROW_SIZE*CL_IN  channel enables, sampled on accepted start
- cfg_bp_ch  in  ROW_SIZE*CL_IN  bypass channels, sampled on accepted start
- cfg_bp_src  in  ROW_SIZE*CL1  bypass sources, sampled on accepted start
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted when w_valid&w_ready
- w_data  in  ROW_SIZE*M  one tap per row
- px_valid  in  1  pixel word valid
- px_ready  out  1  pixel accepted when px_valid&px_ready
- px_data  in  ROW_SIZE*N  one pixel per row
- w_in  out  ROW_SIZE*M  to array
- w_conf  out  1  to array
- cntl_conf  out  1  to array
- d_ch_in  out  ROW_SIZE*CL_IN  to array
- bp_ch_in  out  ROW_SIZE*CL_IN  to array
- bp_src_in  out  ROW_SIZE*CL1  to array
- d_in  out  ROW_SIZE*N  to array
- en_in  out  ROW_SIZE  to array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame

Behaviour:

Reset (synchronous):
- State goes to IDLE; all counters clear.
- Every output is 0, including w_ready and px_ready.
- Weight buffer contents are don't-care.
- rst asserted in any state wins: outputs read 0 in the cycle after rst is sampled. Any partial weight load or frame is abandoned with no further w_conf or en_in.

All outputs are registered.

FSM:
- IDLE:
  - busy=0.
  - On start=1: latch the three cfg buses into shadow registers and go to FILL_W.
- FILL_W:
  - w_ready=1.
  - Each accepted word is written to buffer[wcnt] and wcnt increments.
  - Gaps in w_valid are allowed.
  - When the KSZ-th word is accepted: w_ready=0 the next cycle, wcnt clears, go to SHIFT_W.
- SHIFT_W:
  - Exactly KSZ consecutive cycles with w_conf=1 and w_in=buffer[k], k=0..KSZ-1, oldest first.
  - w_in returns to 0 and w_conf drops in the cycle after tap KSZ-1. Go to CONF.
- CONF:
  - One cycle: cntl_conf=1.
  - d_ch_in/bp_ch_in/bp_src_in drive the shadow values from this cycle on, held until the next accepted start or rst.
  - Go to STREAM.
- STREAM:
  - px_ready=1 while pcnt < LINES*FRAME_LINES.
  - A pixel accepted in cycle t appears in cycle t+1 as d_in=px_data, en_in=all ones.
  - In cycles with no accepted pixel, en_in=0 and d_in holds its last value.
  - On acceptance of pixel LINES*FRAME_LINES: px_ready=0 from the next cycle, go to DONE.
- DONE:
  - done=1 for one cycle, coinciding with the cycle after the last en_in=1.
  - Go to IDLE.

Boundary rules:
- start while busy is ignored; the cfg buses are not re-sampled.
- start and done in the same cycle: start is ignored, since the FSM is not yet in IDLE.
- w_valid outside FILL_W and px_valid outside STREAM are ignored (ready=0). Excess words are never consumed.
- Counter widths: $clog2(KSZ+1) and $clog2(LINES*FRAME_LINES+1). No wrap within a frame.
- Latency start→first w_conf = KSZ accept cycles + 1.
- Total configuration overhead after the last weight is KSZ+1 cycles before px_ready rises.

Test Plan:
- Reset check: hold rst 3 cycles with random inputs → all outputs 0, busy=0, w_ready=0, px_ready=0.
- Back-to-back weights: start, then w_data per row = 1..9 on consecutive cycles → w_conf high exactly 9 consecutive cycles with w_in = 1..9 in order. Then cntl_conf high exactly 1 cycle, with d_ch_in=cfg_d_ch from that cycle.
- Gapped weights: w_valid toggled 1,0,1,0… → still exactly 9 buffered taps, and the w_conf burst remains 9 contiguous cycles with the correct order.
- Throttled stream: px_valid random at 50% for 256 accepts with px_data=pixel index → en_in=4'b1111 on exactly 256 cycles, d_in sequence 0..255 (mod 2^N per row field). done is a single pulse one cycle after the last en_in; px_ready is 0 afterwards with px_valid held high.
- start pulsed mid-STREAM with different cfg values → ignored: d_ch_in/bp_ch_in unchanged, pixel count unaffected.
- rst asserted during SHIFT_W at tap 4 → the next cycle has w_conf=0, w_in=0 and busy=0. A fresh start then requires 9 new weight words.

Source files
------------

// File: rtl/pe_net_feeder_if.sv
// Bundle between the PE-array feeder and its surroundings: upstream weight/pixel
// handshakes, start/config inputs, and the row-parallel array drive outputs.
interface pe_net_feeder_if #(
  parameter int ROW_SIZE = 4,
  parameter int N        = 4,
  parameter int M        = 2,
  parameter int CL_IN    = 4,
  parameter int CL1      = 2
);
  logic                      start;
  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch;
  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch;
  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src;
  logic                      w_valid;
  logic                      w_ready;
  logic [ROW_SIZE*M-1:0]     w_data;
  logic                      px_valid;
  logic                      px_ready;
  logic [ROW_SIZE*N-1:0]     px_data;
  logic [ROW_SIZE*M-1:0]     w_in;
  logic                      w_conf;
  logic                      cntl_conf;
  logic [ROW_SIZE*CL_IN-1:0] d_ch_in;
  logic [ROW_SIZE*CL_IN-1:0] bp_ch_in;
  logic [ROW_SIZE*CL1-1:0]   bp_src_in;
  logic [ROW_SIZE*N-1:0]     d_in;
  logic [ROW_SIZE-1:0]       en_in;
  logic                      busy;
  logic                      done;

  modport master (
    output start, cfg_d_ch, cfg_bp_ch, cfg_bp_src,
    output w_valid, w_data, px_valid, px_data,
    input  w_ready, px_ready, w_in, w_conf, cntl_conf,
    input  d_ch_in, bp_ch_in, bp_src_in, d_in, en_in, busy, done
  );

  modport slave (
    input  start, cfg_d_ch, cfg_bp_ch, cfg_bp_src,
    input  w_valid, w_data, px_valid, px_data,
    output w_ready, px_ready, w_in, w_conf, cntl_conf,
    output d_ch_in, bp_ch_in, bp_src_in, d_in, en_in, busy, done
  );
endinterface

// File: rtl/pe_net_feeder.sv
// Source-side driver for the PE array: buffers one kernel of weights, bursts it
// in on w_conf, pulses cntl_conf, then streams one frame of row-parallel pixels.
module pe_net_feeder #(
  parameter int ROW_SIZE    = 4,
  parameter int N           = 4,
  parameter int M           = 2,
  parameter int CL_IN       = 4,
  parameter int CL1         = 2,
  parameter int KSZ         = 9,
  parameter int LINES       = 16,
  parameter int FRAME_LINES = 16
) (
  input logic            clk,
  input logic            rst,
  pe_net_feeder_if.slave bus
);
  localparam int TOTAL = LINES * FRAME_LINES;
  localparam int WCW   = $clog2(KSZ + 1);
  localparam int PCW   = $clog2(TOTAL + 1);
  localparam int AW    = (KSZ > 1) ? $clog2(KSZ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL_W, S_SHIFT_W, S_CONF, S_STREAM, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [WCW-1:0]            r_wcnt;
  logic [WCW-1:0]            w_wcnt_nxt;
  logic [PCW-1:0]            r_pcnt;
  logic [PCW-1:0]            w_pcnt_nxt;
  logic [ROW_SIZE*M-1:0]     r_buf [KSZ];

  logic [ROW_SIZE*CL_IN-1:0] r_sh_d_ch;
  logic [ROW_SIZE*CL_IN-1:0] r_sh_bp_ch;
  logic [ROW_SIZE*CL1-1:0]   r_sh_bp_src;

  logic                      r_w_ready;
  logic                      r_px_ready;
  logic [ROW_SIZE*M-1:0]     r_w_in;
  logic                      r_w_conf;
  logic                      r_cntl_conf;
  logic [ROW_SIZE*CL_IN-1:0] r_d_ch_in;
  logic [ROW_SIZE*CL_IN-1:0] r_bp_ch_in;
  logic [ROW_SIZE*CL1-1:0]   r_bp_src_in;
  logic [ROW_SIZE*N-1:0]     r_d_in;
  logic [ROW_SIZE-1:0]       r_en_in;
  logic                      r_busy;
  logic                      r_done;

  logic [ROW_SIZE*M-1:0]     w_w_in_nxt;
  logic [ROW_SIZE*N-1:0]     w_d_in_nxt;
  logic [ROW_SIZE-1:0]       w_en_in_nxt;
  logic                      w_w_acc;
  logic                      w_px_acc;

  // Ready registers are only ever high in their own state, so acceptance implies it.
  assign w_w_acc  = bus.w_valid & r_w_ready;
  assign w_px_acc = bus.px_valid & r_px_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pcnt_nxt  = r_pcnt;
    w_w_in_nxt  = '0;
    w_d_in_nxt  = r_d_in;
    w_en_in_nxt = '0;
    case (r_state)
      S_IDLE: begin
        w_pcnt_nxt = '0;
        if (bus.start) w_state_nxt = S_FILL_W;
      end
      S_FILL_W: begin
        if (w_w_acc) begin
          if (r_wcnt == WCW'(KSZ - 1)) begin
            w_state_nxt = S_SHIFT_W;
            w_wcnt_nxt  = '0;
            // Tap 0 is only being written right now when the kernel is one tap long.
            w_w_in_nxt  = (KSZ == 1) ? bus.w_data : r_buf[0];
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end
      S_SHIFT_W: begin
        // r_wcnt is the index of the tap currently on w_in.
        if (r_wcnt == WCW'(KSZ - 1)) begin
          w_state_nxt = S_CONF;
          w_wcnt_nxt  = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
          w_w_in_nxt = r_buf[AW'(r_wcnt + 1'b1)];
        end
      end
      S_CONF: begin
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (r_pcnt == PCW'(TOTAL)) begin
          w_state_nxt = S_DONE;
        end else if (w_px_acc) begin
          w_pcnt_nxt  = r_pcnt + 1'b1;
          w_d_in_nxt  = bus.px_data;
          w_en_in_nxt = '1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_pcnt_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every array-facing output is registered off the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_ready   <= 1'b0;
      r_px_ready  <= 1'b0;
      r_w_in      <= '0;
      r_w_conf    <= 1'b0;
      r_cntl_conf <= 1'b0;
      r_d_ch_in   <= '0;
      r_bp_ch_in  <= '0;
      r_bp_src_in <= '0;
      r_d_in      <= '0;
      r_en_in     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sh_d_ch   <= '0;
      r_sh_bp_ch  <= '0;
      r_sh_bp_src <= '0;
    end else begin
      r_w_ready   <= (w_state_nxt == S_FILL_W);
      r_px_ready  <= (w_state_nxt == S_STREAM) && (w_pcnt_nxt < PCW'(TOTAL));
      r_w_in      <= w_w_in_nxt;
      r_w_conf    <= (w_state_nxt == S_SHIFT_W);
      r_cntl_conf <= (w_state_nxt == S_CONF);
      r_d_in      <= w_d_in_nxt;
      r_en_in     <= w_en_in_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      if ((r_state == S_IDLE) && bus.start) begin
        r_sh_d_ch   <= bus.cfg_d_ch;
        r_sh_bp_ch  <= bus.cfg_bp_ch;
        r_sh_bp_src <= bus.cfg_bp_src;
      end
      if (w_state_nxt == S_CONF) begin
        r_d_ch_in   <= r_sh_d_ch;
        r_bp_ch_in  <= r_sh_bp_ch;
        r_bp_src_in <= r_sh_bp_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_acc) r_buf[AW'(r_wcnt)] <= bus.w_data;
  end

  assign bus.w_ready   = r_w_ready;
  assign bus.px_ready  = r_px_ready;
  assign bus.w_in      = r_w_in;
  assign bus.w_conf    = r_w_conf;
  assign bus.cntl_conf = r_cntl_conf;
  assign bus.d_ch_in   = r_d_ch_in;
  assign bus.bp_ch_in  = r_bp_ch_in;
  assign bus.bp_src_in = r_bp_src_in;
  assign bus.d_in      = r_d_in;
  assign bus.en_in     = r_en_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_pe_net_feeder.sv
// Directed bench for pe_net_feeder: weight burst order, config timing, throttled
// pixel stream, ignored starts and reset mid-burst, checked against scoreboard queues.
module tb_pe_net_feeder;
  localparam int ROW_SIZE = 4, N = 4, M = 2, CL_IN = 4, CL1 = 2;
  localparam int KSZ = 9, LINES = 16, FRAME_LINES = 16;
  localparam int TOTAL = LINES * FRAME_LINES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_net_feeder_if #(.ROW_SIZE(ROW_SIZE), .N(N), .M(M), .CL_IN(CL_IN), .CL1(CL1)) bus ();

  pe_net_feeder #(
    .ROW_SIZE(ROW_SIZE), .N(N), .M(M), .CL_IN(CL_IN), .CL1(CL1),
    .KSZ(KSZ), .LINES(LINES), .FRAME_LINES(FRAME_LINES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [ROW_SIZE*M-1:0] q_w  [$];
  logic [ROW_SIZE*N-1:0] q_px [$];
  logic [ROW_SIZE*CL_IN-1:0] e_dch, e_bpch;
  logic [ROW_SIZE*CL1-1:0]   e_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_SIZE*N-1:0] px_pat(input int idx);
    logic [ROW_SIZE*N-1:0] v;
    for (int r = 0; r < ROW_SIZE; r++) v[r*N +: N] = N'(idx + 5 * r);
    return v;
  endfunction

  function automatic logic [ROW_SIZE*M-1:0] w_pat(input int idx, input int salt);
    return (ROW_SIZE*M)'((idx + 1) * 37 + salt);
  endfunction

  task automatic new_cfg_and_start();
    e_dch  = (ROW_SIZE*CL_IN)'($urandom);
    e_bpch = (ROW_SIZE*CL_IN)'($urandom);
    e_src  = (ROW_SIZE*CL1)'($urandom);
    bus.cfg_d_ch   = e_dch;
    bus.cfg_bp_ch  = e_bpch;
    bus.cfg_bp_src = e_src;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fill_w_ready", bus.w_ready, 1);
    chk("fill_busy", bus.busy, 1);
  endtask

  task automatic load_w(input int nwords, input bit gapped, input int salt);
    int idx = 0;
    int budget = 0;
    bit phase = 1'b1;
    while (idx < nwords && budget < 200) begin
      bus.w_valid = gapped ? phase : 1'b1;
      bus.w_data  = w_pat(idx, salt);
      if (bus.w_valid && bus.w_ready) begin
        q_w.push_back(bus.w_data);
        idx++;
      end
      phase = ~phase;
      budget++;
      tick();
    end
    bus.w_valid = 1'b0;
    chk("w_load_count", idx, nwords);
  endtask

  // Entered on the first SHIFT_W cycle; leaves on the first STREAM cycle.
  task automatic check_shift_conf();
    for (int k = 0; k < KSZ; k++) begin
      chk($sformatf("w_conf_tap%0d", k), bus.w_conf, 1);
      if (q_w.size() > 0) chk($sformatf("w_in_tap%0d", k), bus.w_in, q_w.pop_front());
      else chk($sformatf("w_in_tap%0d_queue", k), q_w.size(), 1);
      tick();
    end
    chk("conf_w_conf_low", {bus.w_conf, bus.w_in}, 0);
    chk("conf_cntl_conf", bus.cntl_conf, 1);
    chk("conf_d_ch_in", bus.d_ch_in, e_dch);
    chk("conf_bp_ch_in", bus.bp_ch_in, e_bpch);
    chk("conf_bp_src_in", bus.bp_src_in, e_src);
    chk("conf_en_in", bus.en_in, 0);
    tick();
    chk("cntl_conf_single", bus.cntl_conf, 0);
  endtask

  task automatic run_stream(input int pct, input bit mid_start, input bit start_at_done);
    int  idx = 0;
    int  en_cnt = 0;
    int  budget = 0;
    bit  prev_en = 1'b0;
    bit  got_done = 1'b0;
    bit  started = 1'b0;
    chk("stream_px_ready_rise", bus.px_ready, 1);
    while (!got_done && budget < 4000) begin
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        chk("done_after_last_en", {prev_en, bus.en_in}, {1'b1, 4'b0000});
        chk("en_count", en_cnt, TOTAL);
        chk("px_ready_at_done", bus.px_ready, 0);
        chk("w_ready_in_stream", bus.w_ready, 0);
        chk("stream_queue_empty", q_px.size(), 0);
        if (start_at_done) begin
          bus.start      = 1'b1;
          bus.cfg_d_ch   = ~e_dch;
          bus.cfg_bp_ch  = ~e_bpch;
          bus.cfg_bp_src = ~e_src;
        end
      end else begin
        if (bus.en_in !== '0) begin
          en_cnt++;
          chk("en_in_all_rows", bus.en_in, 4'hF);
          if (q_px.size() > 0) chk($sformatf("d_in_px%0d", en_cnt - 1), bus.d_in, q_px.pop_front());
          else chk("d_in_unexpected", q_px.size(), 1);
        end
        prev_en = (bus.en_in !== '0);
        bus.start = 1'b0;
        if (mid_start && !started && idx == 100) begin
          started        = 1'b1;
          bus.start      = 1'b1;
          bus.cfg_d_ch   = ~e_dch;
          bus.cfg_bp_ch  = ~e_bpch;
          bus.cfg_bp_src = ~e_src;
        end
        bus.w_valid  = 1'b1;
        bus.px_valid = (idx >= TOTAL) ? 1'b1 : ($urandom_range(99) < pct);
        bus.px_data  = px_pat(idx);
        if (bus.px_valid && bus.px_ready) begin
          q_px.push_back(px_pat(idx));
          idx++;
        end
      end
      budget++;
      tick();
    end
    if (!got_done) chk("done_within_budget", 0, 1);
    bus.start   = 1'b0;
    bus.w_valid = 1'b0;
    chk("done_single_pulse", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    chk("px_ready_after_done", bus.px_ready, 0);
    chk("cfg_held_d_ch", bus.d_ch_in, e_dch);
    chk("cfg_held_bp_ch", bus.bp_ch_in, e_bpch);
    chk("cfg_held_bp_src", bus.bp_src_in, e_src);
    tick();
    chk("start_at_done_ignored", bus.busy, 0);
    chk("no_en_after_done", {bus.en_in, bus.px_ready}, 0);
    bus.px_valid = 1'b0;
    tick();
  endtask

  initial begin
    int quiet;
    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      bus.start      = 1'($urandom);
      bus.cfg_d_ch   = (ROW_SIZE*CL_IN)'($urandom);
      bus.cfg_bp_ch  = (ROW_SIZE*CL_IN)'($urandom);
      bus.cfg_bp_src = (ROW_SIZE*CL1)'($urandom);
      bus.w_valid    = 1'($urandom);
      bus.w_data     = (ROW_SIZE*M)'($urandom);
      bus.px_valid   = 1'($urandom);
      bus.px_data    = (ROW_SIZE*N)'($urandom);
      tick();
    end
    chk("rst_busy", bus.busy, 0);
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_px_ready", bus.px_ready, 0);
    chk("rst_weight_outs", {bus.w_in, bus.w_conf, bus.cntl_conf}, 0);
    chk("rst_cfg_outs", {bus.d_ch_in, bus.bp_ch_in, bus.bp_src_in}, 0);
    chk("rst_stream_outs", {bus.d_in, bus.en_in, bus.done}, 0);
    rst = 1'b0;
    bus.start = 1'b0; bus.w_valid = 1'b0; bus.px_valid = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Run 1: back-to-back weights, throttled stream, start pulsed mid-stream
    new_cfg_and_start();
    load_w(KSZ, 1'b0, 0);
    chk("w_ready_drop", bus.w_ready, 0);
    check_shift_conf();
    run_stream(50, 1'b1, 1'b0);

    // Run 2: gapped weights with stray pixels, full-rate stream, start coinciding with done
    new_cfg_and_start();
    bus.px_valid = 1'b1;
    chk("px_ready_in_fill", bus.px_ready, 0);
    load_w(KSZ, 1'b1, 3);
    bus.px_valid = 1'b0;
    chk("w_ready_drop_gapped", bus.w_ready, 0);
    check_shift_conf();
    run_stream(100, 1'b0, 1'b1);

    // Run 3: reset while tap 4 is on w_in
    new_cfg_and_start();
    load_w(KSZ, 1'b0, 7);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pre_rst_w_conf%0d", k), bus.w_conf, 1);
      chk($sformatf("pre_rst_w_in%0d", k), bus.w_in, q_w.pop_front());
      if (k < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_w.delete();
    chk("rst_shift_w_conf", bus.w_conf, 0);
    chk("rst_shift_w_in", bus.w_in, 0);
    chk("rst_shift_busy", bus.busy, 0);
    chk("rst_shift_cfg", bus.d_ch_in, 0);
    quiet = 0;
    repeat (12) begin
      if (bus.w_conf !== 1'b0 || bus.cntl_conf !== 1'b0 || bus.busy !== 1'b0) quiet++;
      tick();
    end
    chk("abandoned_load_quiet", quiet, 0);

    new_cfg_and_start();
    load_w(KSZ - 1, 1'b0, 11);
    quiet = 0;
    repeat (4) begin
      if (bus.w_conf !== 1'b0) quiet++;
      tick();
    end
    chk("fresh_load_no_burst", quiet, 0);
    chk("fresh_load_still_ready", bus.w_ready, 1);
    load_w(1, 1'b0, 13);
    check_shift_conf();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end
endmodule
